// File: rtl/adc_channel_sequencer_pkg.sv
// Shared definitions for the AD7324 conversion sequencer: FSM states,
// channel numbering, SPI frame field positions and channel rotation.
package adc_channel_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTADC,
    S_WAIT,
    S_START,
    S_BUSY,
    S_CAPT
  } state_t;

  localparam logic [1:0] CH_VOUT = 2'd0;
  localparam logic [1:0] CH_TEMP = 2'd1;
  localparam logic [1:0] CH_VIN  = 2'd2;
  localparam logic [1:0] CH_IOUT = 2'd3;

  localparam int unsigned CHID_HI  = 14;
  localparam int unsigned CHID_LO  = 13;
  localparam int unsigned DATA_MSB = 12;

  // Next enabled channel strictly after cur, wrapping; a single-bit mask
  // yields cur again. Scanning from the far end lets the nearest hit win.
  function automatic logic [1:0] next_ch(input logic [3:0] mask,
                                         input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] c;
    r = cur;
    for (int unsigned k = 4; k >= 1; k--) begin
      c = cur + 2'(k);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_channel_sequencer_if.sv
// Control/data link between the sequencer and the spi_ad7324 core.
interface adc_channel_sequencer_if;
  logic        SPI_RSTp;
  logic        SPI_HOLD;
  logic        SPI_CS;
  logic [15:0] SPI_DATA;

  modport master (output SPI_RSTp, output SPI_HOLD, input SPI_CS, input SPI_DATA);
  modport slave  (input SPI_RSTp, input SPI_HOLD, output SPI_CS, output SPI_DATA);
endinterface

// File: rtl/adc_channel_sequencer_result_fmt.sv
// Truncates a 13-bit two's-complement sample to M bits and flips the sign
// bit, giving offset binary (-4096 -> 0, 0 -> 2^(M-1), +4095 -> 2^M-1).
module adc_result_fmt #(
  parameter int unsigned M = 8
) (
  input  logic [12:0]  i_data,
  output logic [M-1:0] o_result
);

  logic [M-1:0] w_trunc;
  logic         w_unused;

  assign w_trunc  = i_data[12 -: M];
  assign w_unused = ^i_data[12-M:0];

  // Invert the MSB of the truncated value; no rounding
  always_comb begin
    o_result        = w_trunc;
    o_result[M-1]   = ~w_trunc[M-1];
  end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Fixed-rate AD7324 frame scheduler: round-robins enabled channels, captures
// each frame into a per-channel offset-binary result, flags sticky errors.
module adc_channel_sequencer
  import adc_channel_sequencer_pkg::*;
#(
  parameter int unsigned M           = 8,
  parameter int unsigned CONV_PERIOD = 1000,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned RST_CYC     = 4,
  parameter logic [3:0]  CH_MASK     = 4'hF
) (
  input  logic                   CLK20M,
  input  logic                   RSTn,
  input  logic                   EN,
  adc_channel_sequencer_if.master spi,
  output logic [M-1:0]           VOUT,
  output logic [M-1:0]           TEMP,
  output logic [M-1:0]           VIN,
  output logic [M-1:0]           IOUT,
  output logic                   SAMPLE_STB,
  output logic [1:0]             SAMPLE_CH,
  output logic                   ERR_TIMEOUT,
  output logic                   ERR_CHID,
  output logic                   ERR_OVR
);

  localparam int unsigned PW = $clog2(CONV_PERIOD);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(CONV_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
  localparam logic [1:0]    CH_FIRST = next_ch(CH_MASK, 2'd3);

  state_t        r_state, w_next;
  logic [PW-1:0] r_per_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [RW-1:0] r_rst_cnt;
  logic          r_cs_s1, r_cs_s2, r_cs_s3;
  logic [1:0]    r_exp_ch;
  logic [M-1:0]  r_vout, r_temp, r_vin, r_iout;
  logic          r_stb;
  logic [1:0]    r_sch;
  logic          r_eto, r_ech, r_eov;

  logic          w_tick, w_done, w_in_frame, w_unused;
  logic [1:0]    w_rep_ch;
  logic [M-1:0]  w_fmt;

  assign w_done     = r_cs_s2 & ~r_cs_s3;
  assign w_tick     = (r_per_cnt == '0);
  assign w_in_frame = (r_state == S_START) || (r_state == S_BUSY) || (r_state == S_CAPT);
  assign w_rep_ch   = spi.SPI_DATA[CHID_HI:CHID_LO];
  assign w_unused   = spi.SPI_DATA[15];

  assign spi.SPI_RSTp = (r_state == S_IDLE) || (r_state == S_RSTADC);
  assign spi.SPI_HOLD = (r_state == S_START);

  assign VOUT        = r_vout;
  assign TEMP        = r_temp;
  assign VIN         = r_vin;
  assign IOUT        = r_iout;
  assign SAMPLE_STB  = r_stb;
  assign SAMPLE_CH   = r_sch;
  assign ERR_TIMEOUT = r_eto;
  assign ERR_CHID    = r_ech;
  assign ERR_OVR     = r_eov;

  adc_result_fmt #(.M(M)) u_fmt (
    .i_data   (spi.SPI_DATA[DATA_MSB:0]),
    .o_result (w_fmt)
  );

  // State register
  always_ff @(posedge CLK20M or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; a timed-out frame re-resets the ADC without advancing
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (EN) w_next = S_RSTADC;
      S_RSTADC: if (r_rst_cnt == RST_LAST) w_next = S_WAIT;
      S_WAIT: begin
        if (!EN)        w_next = S_IDLE;
        else if (w_tick) w_next = S_START;
      end
      S_START:  w_next = S_BUSY;
      S_BUSY: begin
        if (w_done)                   w_next = S_CAPT;
        else if (r_to_cnt == TO_LAST) w_next = S_RSTADC;
      end
      S_CAPT:   w_next = EN ? S_WAIT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Two-flop CS synchroniser plus one delay stage for rising-edge detect
  always_ff @(posedge CLK20M or negedge RSTn) begin
    if (!RSTn) begin
      r_cs_s1 <= 1'b1;
      r_cs_s2 <= 1'b1;
      r_cs_s3 <= 1'b1;
    end else begin
      r_cs_s1 <= spi.SPI_CS;
      r_cs_s2 <= r_cs_s1;
      r_cs_s3 <= r_cs_s2;
    end
  end

  // ADC reset pulse length, timeout and frame-period counters
  always_ff @(posedge CLK20M or negedge RSTn) begin
    if (!RSTn) begin
      r_rst_cnt <= '0;
      r_to_cnt  <= '0;
      r_per_cnt <= '0;
    end else begin
      r_rst_cnt <= (r_state == S_RSTADC) ? r_rst_cnt + 1'b1 : '0;
      if (r_state == S_START)     r_to_cnt <= '0;
      else if (r_state == S_BUSY) r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state == S_RSTADC && w_next == S_WAIT) r_per_cnt <= '0;
      else if (w_tick)                            r_per_cnt <= PER_LAST;
      else                                        r_per_cnt <= r_per_cnt - 1'b1;
    end
  end

  // Result capture, sample strobe, channel tracking and sticky errors
  always_ff @(posedge CLK20M or negedge RSTn) begin
    if (!RSTn) begin
      r_vout   <= '0;
      r_temp   <= '0;
      r_vin    <= '0;
      r_iout   <= '0;
      r_stb    <= 1'b0;
      r_sch    <= '0;
      r_eto    <= 1'b0;
      r_ech    <= 1'b0;
      r_eov    <= 1'b0;
      r_exp_ch <= CH_FIRST;
    end else begin
      r_stb <= 1'b0;
      if (r_state == S_CAPT) begin
        r_stb <= 1'b1;
        r_sch <= w_rep_ch;
        case (w_rep_ch)
          CH_VOUT: r_vout <= w_fmt;
          CH_TEMP: r_temp <= w_fmt;
          CH_VIN:  r_vin  <= w_fmt;
          CH_IOUT: r_iout <= w_fmt;
        endcase
        if (w_rep_ch != r_exp_ch) r_ech <= 1'b1;
        // Following the reported channel also resynchronises after a mismatch
        r_exp_ch <= next_ch(CH_MASK, w_rep_ch);
      end
      if (r_state == S_BUSY && !w_done && r_to_cnt == TO_LAST) r_eto <= 1'b1;
      if (w_tick && w_in_frame) r_eov <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Bench for adc_channel_sequencer: two instances (default config, and a
// 0101-mask / 64-cycle-period config) each driven by a behavioural core model.
module tb_adc_channel_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A: defaults ----------------
  logic       rstn_a, en_a;
  logic [7:0] a_vout, a_temp, a_vin, a_iout;
  logic       a_stb, a_eto, a_ech, a_eov;
  logic [1:0] a_sch;
  adc_channel_sequencer_if ifa ();

  adc_channel_sequencer #(.M(8), .CONV_PERIOD(1000), .TIMEOUT(64), .RST_CYC(4), .CH_MASK(4'hF)) dut_a (
    .CLK20M(clk), .RSTn(rstn_a), .EN(en_a), .spi(ifa),
    .VOUT(a_vout), .TEMP(a_temp), .VIN(a_vin), .IOUT(a_iout),
    .SAMPLE_STB(a_stb), .SAMPLE_CH(a_sch),
    .ERR_TIMEOUT(a_eto), .ERR_CHID(a_ech), .ERR_OVR(a_eov)
  );

  // ---------------- instance B: mask 0101, short period ----------------
  logic       rstn_b, en_b;
  logic [7:0] b_vout, b_temp, b_vin, b_iout;
  logic       b_stb, b_eto, b_ech, b_eov;
  logic [1:0] b_sch;
  adc_channel_sequencer_if ifb ();

  adc_channel_sequencer #(.M(8), .CONV_PERIOD(64), .TIMEOUT(100), .RST_CYC(4), .CH_MASK(4'b0101)) dut_b (
    .CLK20M(clk), .RSTn(rstn_b), .EN(en_b), .spi(ifb),
    .VOUT(b_vout), .TEMP(b_temp), .VIN(b_vin), .IOUT(b_iout),
    .SAMPLE_STB(b_stb), .SAMPLE_CH(b_sch),
    .ERR_TIMEOUT(b_eto), .ERR_CHID(b_ech), .ERR_OVR(b_eov)
  );

  // ---------------- core models ----------------
  int          a_lat = 20, b_lat = 10;
  bit          a_withhold = 1'b0;
  logic [1:0]  a_ch, b_ch;
  logic [12:0] a_dat, b_dat;
  int unsigned hold_a[$];
  int unsigned hold_b[$];

  initial begin
    ifa.SPI_CS = 1'b1; ifa.SPI_DATA = '0;
    ifb.SPI_CS = 1'b1; ifb.SPI_DATA = '0;
  end

  always @(negedge clk) begin
    if (ifa.SPI_HOLD === 1'b1) hold_a.push_back(cyc);
    if (ifb.SPI_HOLD === 1'b1) hold_b.push_back(cyc);
  end

  // Core A: CS low for the frame, data + CS rise after a_lat cycles; when
  // withholding, CS stays low until the sequencer resets the core.
  always @(negedge clk) begin
    if (ifa.SPI_HOLD === 1'b1) begin
      ifa.SPI_CS = 1'b0;
      if (a_withhold) begin
        a_withhold = 1'b0;
        for (int k = 0; k < 200 && ifa.SPI_RSTp !== 1'b1; k++) @(negedge clk);
      end else begin
        repeat (a_lat) @(negedge clk);
      end
      ifa.SPI_DATA = {1'b0, a_ch, a_dat};
      ifa.SPI_CS   = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (ifb.SPI_HOLD === 1'b1) begin
      ifb.SPI_CS = 1'b0;
      repeat (b_lat) @(negedge clk);
      ifb.SPI_DATA = {1'b0, b_ch, b_dat};
      ifb.SPI_CS   = 1'b1;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic int nxt(input logic [3:0] mask, input int ch);
    int c;
    c = ch;
    do c = (c + 1) % 4; while (!mask[c]);
    return c;
  endfunction

  // Signed 13-bit value shifted to 0..8191, keeping the top 8 bits
  function automatic int ob(input logic [12:0] d);
    int v;
    v = d[12] ? int'(d) - 8192 : int'(d);
    return (v + 4096) / 32;
  endfunction

  function automatic logic [7:0] a_reg(input int ch);
    case (ch)
      0: return a_vout;
      1: return a_temp;
      2: return a_vin;
      default: return a_iout;
    endcase
  endfunction

  function automatic logic [7:0] b_reg(input int ch);
    case (ch)
      0: return b_vout;
      1: return b_temp;
      2: return b_vin;
      default: return b_iout;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_stb_a(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2500 && !ok; k++) begin
      @(negedge clk);
      ok = (a_stb === 1'b1);
    end
    chk({name, "_stb_seen"}, 32'(ok), 1);
  endtask

  task automatic wait_stb_b(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2500 && !ok; k++) begin
      @(negedge clk);
      ok = (b_stb === 1'b1);
    end
    chk({name, "_stb_seen"}, 32'(ok), 1);
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic [12:0] dat;
    logic [7:0]  res;
  } vec_t;

  // ---------------- sequence for instance A ----------------
  task automatic seq_a();
    vec_t        tbl [8];
    int          ra, n_hi, sz;
    int unsigned t_e;
    logic [12:0] d;

    tbl[0] = '{2'd0, 13'h1000, 8'h00};
    tbl[1] = '{2'd1, 13'h0000, 8'h80};
    tbl[2] = '{2'd2, 13'h0FFF, 8'hFF};
    tbl[3] = '{2'd3, 13'h1FFF, 8'h7F};
    tbl[4] = '{2'd0, 13'h0020, 8'h81};
    tbl[5] = '{2'd1, 13'h1FE0, 8'h7F};
    tbl[6] = '{2'd2, 13'h001F, 8'h80};
    tbl[7] = '{2'd3, 13'h0800, 8'hC0};

    rstn_a = 1'b0; en_a = 1'b0; a_ch = '0; a_dat = '0;
    repeat (3) @(negedge clk);
    chk("a_rst_rstp", ifa.SPI_RSTp, 1);
    chk("a_rst_hold", ifa.SPI_HOLD, 0);
    chk("a_rst_results", {a_vout, a_temp, a_vin, a_iout}, 0);
    chk("a_rst_sample", {a_stb, a_sch}, 0);
    chk("a_rst_errs", {a_eto, a_ech, a_eov}, 0);
    rstn_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_idle_rstp", ifa.SPI_RSTp, 1);

    a_ch = tbl[0].ch; a_dat = tbl[0].dat;
    en_a = 1'b1;
    n_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifa.SPI_RSTp === 1'b1) n_hi++;
      else break;
    end
    chk("a_rstp_cycles", n_hi, 4);
    chk("a_hold_after_wait", ifa.SPI_HOLD, 0);
    @(negedge clk);
    chk("a_first_hold", ifa.SPI_HOLD, 1);

    for (int i = 0; i < 8; i++) begin
      a_ch = tbl[i].ch; a_dat = tbl[i].dat;
      wait_stb_a("a_tbl");
      chk("a_tbl_ch", a_sch, tbl[i].ch);
      chk("a_tbl_res", a_reg(tbl[i].ch), tbl[i].res);
      if (i == 3) chk("a_tbl_all", {a_vout, a_temp, a_vin, a_iout}, 32'h0080FF7F);
      @(negedge clk);
      chk("a_stb_one_cycle", a_stb, 0);
    end
    chk("a_period", (hold_a.size() >= 2) ? hold_a[1] - hold_a[0] : 0, 1000);
    chk("a_tbl_errs", {a_eto, a_ech, a_eov}, 0);
    ra = 0;

    for (int i = 0; i < 12; i++) begin
      d = 13'($urandom);
      a_ch = 2'(ra); a_dat = d; a_lat = $urandom_range(5, 50);
      wait_stb_a("a_rnd");
      chk("a_rnd_ch", a_sch, ra);
      chk("a_rnd_res", a_reg(ra), ob(d));
      chk("a_rnd_errs", {a_eto, a_ech, a_eov}, 0);
      ra = nxt(4'hF, ra);
    end

    // Withheld frame: abort after TIMEOUT, ADC re-reset, same channel retried
    a_lat = 20; a_withhold = 1'b1;
    d = 13'($urandom); a_ch = 2'(ra); a_dat = d;
    t_e = 0;
    for (int k = 0; k < 2500 && t_e == 0; k++) begin
      @(negedge clk);
      if (a_eto === 1'b1) t_e = cyc;
    end
    chk("a_to_seen", 32'(t_e != 0), 1);
    chk("a_to_gap", t_e - hold_a[$], 65);
    chk("a_to_rstp", ifa.SPI_RSTp, 1);
    wait_stb_a("a_retry");
    chk("a_retry_hold", hold_a[$] - t_e, 5);
    chk("a_retry_ch", a_sch, ra);
    chk("a_retry_res", a_reg(ra), ob(d));
    chk("a_retry_errs", {a_eto, a_ech}, 2'b10);
    ra = nxt(4'hF, ra);

    // EN dropped mid-frame: frame still captured, then idle
    sz = hold_a.size();
    d = 13'($urandom); a_ch = 2'(ra); a_dat = d; a_lat = 30;
    for (int k = 0; k < 2500 && hold_a.size() == sz; k++) @(negedge clk);
    @(negedge clk);
    en_a = 1'b0;
    wait_stb_a("a_endrop");
    chk("a_endrop_ch", a_sch, ra);
    chk("a_endrop_res", a_reg(ra), ob(d));
    ra = nxt(4'hF, ra);
    repeat (3) @(negedge clk);
    chk("a_endrop_idle", ifa.SPI_RSTp, 1);
    sz = hold_a.size();
    repeat (1200) @(negedge clk);
    chk("a_idle_no_hold", hold_a.size() - sz, 0);
    en_a = 1'b1;

    // Reported chID 3 while 1 is expected
    for (int j = 0; j < 4 && ra != 1; j++) begin
      d = 13'($urandom); a_ch = 2'(ra); a_dat = d;
      wait_stb_a("a_pre");
      chk("a_pre_ch", a_sch, ra);
      chk("a_pre_res", a_reg(ra), ob(d));
      ra = nxt(4'hF, ra);
    end
    chk("a_pre_ech", a_ech, 0);
    d = 13'($urandom); a_ch = 2'd3; a_dat = d;
    wait_stb_a("a_chid");
    chk("a_chid_ch", a_sch, 3);
    chk("a_chid_iout", a_iout, ob(d));
    chk("a_chid_err", a_ech, 1);
    ra = nxt(4'hF, 3);
    d = 13'($urandom); a_ch = 2'(ra); a_dat = d;
    wait_stb_a("a_post");
    chk("a_post_ch", a_sch, 0);
    chk("a_post_vout", a_vout, ob(d));

    // Asynchronous reset in the middle of a frame
    sz = hold_a.size(); a_lat = 40;
    for (int k = 0; k < 2500 && hold_a.size() == sz; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    rstn_a = 1'b0;
    #1;
    chk("a_mid_rst_rstp", ifa.SPI_RSTp, 1);
    chk("a_mid_rst_hold", ifa.SPI_HOLD, 0);
    chk("a_mid_rst_results", {a_vout, a_temp, a_vin, a_iout}, 0);
    chk("a_mid_rst_sample", {a_stb, a_sch}, 0);
    chk("a_mid_rst_errs", {a_eto, a_ech, a_eov}, 0);
  endtask

  // ---------------- sequence for instance B ----------------
  task automatic seq_b();
    int          rb, sz;
    logic [12:0] d;

    rstn_b = 1'b0; en_b = 1'b0; b_ch = '0; b_dat = '0; b_lat = 10;
    repeat (3) @(negedge clk);
    chk("b_rst_results", {b_vout, b_temp, b_vin, b_iout}, 0);
    chk("b_rst_errs", {b_eto, b_ech, b_eov}, 0);
    rstn_b = 1'b1;
    @(negedge clk);
    rb = 0;
    en_b = 1'b1;

    for (int i = 0; i < 6; i++) begin
      d = 13'($urandom); b_ch = 2'(rb); b_dat = d;
      wait_stb_b("b_mask");
      chk("b_mask_ch", b_sch, rb);
      chk("b_mask_res", b_reg(rb), ob(d));
      chk("b_mask_errs", {b_eto, b_ech, b_eov}, 0);
      rb = nxt(4'b0101, rb);
    end
    chk("b_mask_unused_regs", {b_temp, b_iout}, 0);
    chk("b_period", hold_b[$] - hold_b[$-1], 64);

    // Frames longer than the period: every other tick is dropped
    sz = hold_b.size(); b_lat = 66;
    for (int i = 0; i < 3; i++) begin
      d = 13'($urandom); b_ch = 2'(rb); b_dat = d;
      wait_stb_b("b_ovr");
      chk("b_ovr_ch", b_sch, rb);
      chk("b_ovr_res", b_reg(rb), ob(d));
      rb = nxt(4'b0101, rb);
    end
    chk("b_ovr_err", {b_eto, b_ech, b_eov}, 3'b001);
    chk("b_ovr_gap1", (hold_b.size() >= sz + 3) ? hold_b[sz+1] - hold_b[sz] : 0, 128);
    chk("b_ovr_gap2", (hold_b.size() >= sz + 3) ? hold_b[sz+2] - hold_b[sz+1] : 0, 128);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
